// File: rtl/store_buffer_pkg.sv
// Shared enable levels, byte-select type and word-index helper for the store buffer.
// Word addresses ignore the two byte-offset bits of a byte address.
`define SB_WORD_IDX(a, aw) a[(aw)-1:2]

package store_buffer_pkg;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic READ_ENABLE  = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;

  localparam int BYTE_SEL_W = 4;
  typedef logic [BYTE_SEL_W-1:0] byte_sel_t;
  typedef logic [31:0]           word_t;

endpackage

// File: rtl/sb_fwd_merge.sv
// Load forwarding: per byte lane, the youngest buffered entry with a matching word
// address and lane enable supplies the byte; otherwise the RAM read byte is used.
module sb_fwd_merge
  import store_buffer_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int ADDR_W = 32,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int WORD_W = ADDR_W - 2
) (
  input  logic              ld_valid,
  input  logic [WORD_W-1:0] ld_word,
  input  logic [PTR_W-1:0]  head,
  input  logic [CNT_W-1:0]  count,
  input  logic [WORD_W-1:0] ent_word [DEPTH],
  input  word_t             ent_data [DEPTH],
  input  byte_sel_t         ent_sel  [DEPTH],
  input  word_t             ram_rdata,
  output word_t             ld_data
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so a younger match overwrites an older one per lane.
  always_comb begin
    ld_data = '0;
    idx     = '0;
    if (ld_valid) begin
      ld_data = ram_rdata;
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + PTR_W'(i);
        if ((CNT_W'(i) < count) && (ent_word[idx] == ld_word)) begin
          for (int b = 0; b < BYTE_SEL_W; b++) begin
            if (ent_sel[idx][b]) begin
              ld_data[8*b +: 8] = ent_data[idx][8*b +: 8];
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between MEM stage and data RAM: FIFO of stores drained in load-free cycles.
// Optional STORE_BUFFER_COALESCE_EN merges a store into the youngest entry of the same word.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [3:0]        st_sel,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic [31:0]       ld_data,
  output logic              empty,
  output logic              ram_ce,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [31:0]       ram_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_wsel
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WORD_W = ADDR_W - 2;

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  word_t             data_q [DEPTH];
  word_t             data_d [DEPTH];
  byte_sel_t         sel_q  [DEPTH];
  byte_sel_t         sel_d  [DEPTH];
  logic [WORD_W-1:0] ent_word [DEPTH];

  logic has_room;
  logic merge_hit;
  logic st_fire;
  logic push;
  logic pop;

  // Handshake: a store transfers on a cycle with st_valid & st_ready; st_ready never
  // depends on st_valid, and a transfer with st_sel == 0 is consumed without effect.
  assign has_room = (count_q < CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = !empty && !ld_valid;

`ifdef STORE_BUFFER_COALESCE_EN
  logic [PTR_W-1:0] young_idx;
  assign young_idx = tail_q - PTR_W'(1);
  // The head leaving this cycle must not absorb bytes that would then never reach RAM.
  assign merge_hit = !empty
                  && (`SB_WORD_IDX(addr_q[young_idx], ADDR_W) == `SB_WORD_IDX(st_addr, ADDR_W))
                  && !(pop && (young_idx == head_q));
`else
  assign merge_hit = 1'b0;
`endif

  assign st_ready = has_room || merge_hit;
  assign st_fire  = st_valid && st_ready && (st_sel != '0);
  assign push     = st_fire && !merge_hit;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (push) begin
      addr_d[tail_q] = st_addr;
      data_d[tail_q] = st_data;
      sel_d[tail_q]  = st_sel;
      tail_d         = tail_q + PTR_W'(1);
    end
`ifdef STORE_BUFFER_COALESCE_EN
    if (st_fire && merge_hit) begin
      for (int b = 0; b < BYTE_SEL_W; b++) begin
        if (st_sel[b]) begin
          data_d[young_idx][8*b +: 8] = st_data[8*b +: 8];
        end
      end
      sel_d[young_idx] = sel_q[young_idx] | st_sel;
    end
`endif
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        sel_q[i]  <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_word[i] = `SB_WORD_IDX(addr_q[i], ADDR_W);
    end
  end

  sb_fwd_merge #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fwd (
    .ld_valid  (ld_valid),
    .ld_word   (`SB_WORD_IDX(ld_addr, ADDR_W)),
    .head      (head_q),
    .count     (count_q),
    .ent_word  (ent_word),
    .ent_data  (data_q),
    .ent_sel   (sel_q),
    .ram_rdata (ram_rdata),
    .ld_data   (ld_data)
  );

  assign ram_re    = ld_valid ? READ_ENABLE : !READ_ENABLE;
  assign ram_we    = pop ? WRITE_ENABLE : !WRITE_ENABLE;
  assign ram_ce    = (ld_valid || pop) ? CHIP_ENABLE : !CHIP_ENABLE;
  assign ram_raddr = ld_addr;
  assign ram_waddr = addr_q[head_q];
  assign ram_wdata = data_q[head_q];
  assign ram_wsel  = sel_q[head_q];

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: expected drains and load words are queued by the
// stimulus and checked by a negedge monitor whenever the DUT drains or serves a load.
module tb_store_buffer;

  localparam int ADDR_W = 32;
  localparam int WR_W   = 68;
  localparam logic [31:0] BLK_ADDR = 32'h0000_0F00;
  localparam logic [31:0] BLK_DATA = 32'hC0FF_EE00;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_sel;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        empty;
  logic        ram_ce;
  logic        ram_re;
  logic [31:0] ram_raddr;
  logic [31:0] ram_rdata;
  logic        ram_we;
  logic [31:0] ram_waddr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wsel;

  logic [WR_W-1:0] wr_q[$];
  logic [31:0]     ld_q[$];
  logic [WR_W-1:0] wr_e;
  logic [31:0]     ld_e;
  int total = 0;
  int bad   = 0;

  store_buffer #(.DEPTH(4), .ADDR_W(ADDR_W)) dut (
    .clock     (clk),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_sel    (st_sel),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .empty     (empty),
    .ram_ce    (ram_ce),
    .ram_re    (ram_re),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_wsel  (ram_wsel)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      chk("ram_re", {31'd0, ram_re}, {31'd0, ld_valid});
      if (ram_we) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_drain", ram_waddr, 32'hFFFF_FFFF);
        end else begin
          wr_e = wr_q.pop_front();
          chk("drain_addr", ram_waddr, wr_e[67:36]);
          chk("drain_data", ram_wdata, wr_e[35:4]);
          chk("drain_sel", {28'd0, ram_wsel}, {28'd0, wr_e[3:0]});
          chk("drain_ce", {31'd0, ram_ce}, 32'd1);
        end
      end
      if (ld_valid) begin
        ld_e = (ld_q.size() != 0) ? ld_q.pop_front() : BLK_DATA;
        chk("ld_data", ld_data, ld_e);
      end else begin
        chk("ld_idle_zero", ld_data, 32'd0);
      end
    end
  end

  // driver tasks: all start and end one time unit after a rising edge
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    st_valid = 1'b1; st_addr = a; st_data = d; st_sel = s;
    @(negedge clk);
    while (!st_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!st_ready) chk("store_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    st_valid = 1'b0;
  endtask

  task automatic wait_empty(input string nm);
    int n = 0;
    @(negedge clk);
    while (!empty && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {31'd0, empty}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic block_loads();
    ld_valid = 1'b1; ld_addr = BLK_ADDR; ram_rdata = BLK_DATA;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] rd, input logic [31:0] exp);
    ld_valid = 1'b1; ld_addr = a; ram_rdata = rd;
    ld_q.push_back(exp);
    @(posedge clk); #1;
    ld_addr = BLK_ADDR; ram_rdata = BLK_DATA;
  endtask

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_sel = '0;
    ld_valid = 1'b0; ld_addr = '0; ram_rdata = BLK_DATA;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_st_ready", {31'd0, st_ready}, 32'd1);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    @(posedge clk); #1;

    // 1: single store drains the cycle after acceptance
    wr_q.push_back({32'h0000_0100, 32'hDEAD_BEEF, 4'b1111});
    do_store(32'h0000_0100, 32'hDEAD_BEEF, 4'b1111);
    @(negedge clk);
    chk("t1_we_next", {31'd0, ram_we}, 32'd1);
    chk("t1_waddr", ram_waddr, 32'h0000_0100);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_empty_after", {31'd0, empty}, 32'd1);
    @(posedge clk); #1;

    // 2: fill behind loads, 5th store stalls, then drain with push+pop overlap
    block_loads();
    for (int i = 0; i < 4; i++) begin
      wr_q.push_back({32'h0000_0500 + 32'(4*i), 32'h1000_0000 + 32'(i), 4'b1111});
      do_store(32'h0000_0500 + 32'(4*i), 32'h1000_0000 + 32'(i), 4'b1111);
    end
    @(negedge clk);
    chk("t2_full_ready", {31'd0, st_ready}, 32'd0);
    st_valid = 1'b1; st_addr = 32'h0000_0510; st_data = 32'h1000_0004; st_sel = 4'b1111;
    wr_q.push_back({32'h0000_0510, 32'h1000_0004, 4'b1111});
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_stall", {31'd0, st_ready}, 32'd0);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    @(negedge clk);
    chk("t2_no_push_on_pop", {31'd0, st_ready}, 32'd0);
    chk("t2_we0", {31'd0, ram_we}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_ready_after_pop", {31'd0, st_ready}, 32'd1);
    chk("t2_we1", {31'd0, ram_we}, 32'd1);
    @(posedge clk); #1;
    st_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_we_run", {31'd0, ram_we}, 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("t2_empty", {31'd0, empty}, 32'd1);
    @(posedge clk); #1;

    // 3: partial forwarding over RAM data
    block_loads();
    wr_q.push_back({32'h0000_0200, 32'h0000_AABB, 4'b0011});
    do_store(32'h0000_0200, 32'h0000_AABB, 4'b0011);
    do_load(32'h0000_0200, 32'h1122_3344, 32'h1122_AABB);
    ld_valid = 1'b0;
    wait_empty("t3_drained");

    // 4: youngest entry wins per lane, older entry still supplies its own lanes
    block_loads();
`ifdef STORE_BUFFER_COALESCE_EN
    wr_q.push_back({32'h0000_0300, 32'h6600_00EE, 4'b1001});
`else
    wr_q.push_back({32'h0000_0300, 32'h5500_00EE, 4'b1001});
    wr_q.push_back({32'h0000_0300, 32'h6600_0000, 4'b1000});
`endif
    do_store(32'h0000_0300, 32'h5500_00EE, 4'b1001);
    do_store(32'h0000_0300, 32'h6600_0000, 4'b1000);
    do_load(32'h0000_0302, 32'hA1B2_C3D4, 32'h66B2_C3EE);
    ld_valid = 1'b0;
    wait_empty("t4_drained");

    // zero byte select: accepted, nothing buffered
    do_store(32'h0000_0600, 32'h1234_5678, 4'b0000);
    @(negedge clk);
    chk("sel0_empty", {31'd0, empty}, 32'd1);
    @(posedge clk); #1;

    // 5: two stores to one word while drain is blocked
    block_loads();
`ifdef STORE_BUFFER_COALESCE_EN
    wr_q.push_back({32'h0000_0400, 32'h0000_BBAA, 4'b0011});
`else
    wr_q.push_back({32'h0000_0400, 32'h0000_00AA, 4'b0001});
    wr_q.push_back({32'h0000_0400, 32'h0000_BB00, 4'b0010});
`endif
    do_store(32'h0000_0400, 32'h0000_00AA, 4'b0001);
    do_store(32'h0000_0400, 32'h0000_BB00, 4'b0010);
    do_load(32'h0000_0400, 32'h0102_0304, 32'h0102_BBAA);
    ld_valid = 1'b0;
    wait_empty("t5_drained");

    // 6: reset lands on a drain cycle, buffered stores are discarded
    block_loads();
    for (int i = 0; i < 3; i++) begin
      do_store(32'h0000_0700 + 32'(4*i), 32'hBAD0_0000 + 32'(i), 4'b1111);
    end
    ld_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("t6_drain_cycle", {31'd0, ram_we}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t6_we_off", {31'd0, ram_we}, 32'd0);
    chk("t6_empty", {31'd0, empty}, 32'd1);
    chk("t6_st_ready", {31'd0, st_ready}, 32'd1);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;

    chk("wr_q_left", 32'(wr_q.size()), 32'd0);
    chk("ld_q_left", 32'(ld_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
